// File: rtl/sram_responder.sv
// sram_responder: async-SRAM-style slave (CE/OE/WE/UB/LB, active-low) backed by a 2^DEPTH_LOG2 x 16 array.
// Define SRAM_ACCESS_CNT_EN to add saturating Rd_count/Wr_count access counters.
module sram_responder #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  output logic        Rd_valid,
  output logic        Wr_done,
  output logic        Err_short
`ifdef SRAM_ACCESS_CNT_EN
  ,
  output logic [15:0] Rd_count,
  output logic [15:0] Wr_count
`endif
);
  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2} state_t;
  state_t state_q, state_d;
  logic [15:0] mem_q [2**DEPTH_LOG2];
  logic [15:0] data_q, data_d;
  logic wr_done_q, err_q;
  logic rd_load, commit, abort;
  logic [DEPTH_LOG2-1:0] addr;
  logic unused_addr;
  assign addr = ADDR[DEPTH_LOG2-1:0];
  assign unused_addr = ^ADDR;
  assign data_d = {Mem_UB ? 8'h00 : mem_q[addr][15:8], Mem_LB ? 8'h00 : mem_q[addr][7:0]};
  always_comb begin
    state_d = state_q;
    rd_load = 1'b0;
    commit = 1'b0;
    abort = 1'b0;
    case (state_q)
      IDLE: state_d = (!Mem_CE && !Mem_WE) ? WR1 : (!Mem_CE && !Mem_OE) ? RD1 : IDLE;
      RD1, RD2: begin
        // WE low always wins, even mid-read
        rd_load = !Mem_CE && Mem_WE && !Mem_OE;
        state_d = Mem_CE ? IDLE : !Mem_WE ? WR1 : Mem_OE ? IDLE : RD2;
      end
      WR1: begin
        commit = !Mem_CE && !Mem_WE;
        abort = !commit;
        state_d = commit ? WR2 : IDLE;
      end
      WR2: state_d = (Mem_CE || Mem_WE) ? IDLE : WR2;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      data_q <= '0;
      wr_done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_done_q <= commit;
      if (rd_load) data_q <= data_d;
      if (abort) err_q <= 1'b1;
    end
  end
  // Memory survives reset; a reset edge never commits a write
  always_ff @(posedge Clk) begin
    if (!Reset && commit) begin
      if (!Mem_UB) mem_q[addr][15:8] <= Data_from_CPU[15:8];
      if (!Mem_LB) mem_q[addr][7:0] <= Data_from_CPU[7:0];
    end
  end
  assign Rd_valid = state_q == RD2;
  assign Data_to_CPU = Rd_valid ? data_q : 16'h0000;
  assign Wr_done = wr_done_q;
  assign Err_short = err_q;
`ifdef SRAM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_load && state_q == RD1 && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (commit && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end
  assign Rd_count = rd_cnt_q;
  assign Wr_count = wr_cnt_q;
`endif
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed self-checking bench; read data checked through an expected-value queue.
module tb_sram_responder;
  logic Clk = 1'b0, Reset = 1'b1;
  logic ce = 1'b1, oe = 1'b1, we = 1'b1, ub = 1'b0, lb = 1'b0;
  logic [15:0] addr = '0, din = '0;
  logic [15:0] Data_to_CPU;
  logic Rd_valid, Wr_done, Err_short;
  int n_tests = 0, n_fail = 0;
  logic [15:0] sb [$];
`ifdef SRAM_ACCESS_CNT_EN
  logic [15:0] Rd_count, Wr_count;
`endif
  sram_responder dut (
    .Clk(Clk), .Reset(Reset), .Mem_CE(ce), .Mem_OE(oe), .Mem_WE(we), .Mem_UB(ub), .Mem_LB(lb),
    .ADDR(addr), .Data_from_CPU(din), .Data_to_CPU(Data_to_CPU), .Rd_valid(Rd_valid),
    .Wr_done(Wr_done), .Err_short(Err_short)
`ifdef SRAM_ACCESS_CNT_EN
    , .Rd_count(Rd_count), .Wr_count(Wr_count)
`endif
  );
  always #5 Clk = ~Clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pop_chk(input string tag);
    chk({tag, "_valid"}, {15'd0, Rd_valid}, 16'd1);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else chk(tag, Data_to_CPU, sb.pop_front());
  endtask
  task automatic idle();
    ce = 1'b1; oe = 1'b1; we = 1'b1; ub = 1'b0; lb = 1'b0;
    cyc();
  endtask
  task automatic wr(input logic [15:0] a, d, input logic u, l, o, input int n);
    ce = 1'b0; we = 1'b0; oe = o; addr = a; din = d; ub = u; lb = l;
    repeat (n) cyc();
    if (n >= 2) chk("wr_done", {15'd0, Wr_done}, 16'd1);
    idle();
    chk("wr_done_drop", {15'd0, Wr_done}, 16'd0);
  endtask
  task automatic rd(input logic [15:0] a, input logic u, l, input logic [15:0] exp);
    sb.push_back(exp);
    ce = 1'b0; oe = 1'b0; we = 1'b1; addr = a; ub = u; lb = l;
    cyc();
    chk("rd1_valid", {15'd0, Rd_valid}, 16'd0);
    cyc();
    pop_chk("rd_data");
    idle();
    chk("rd_idle_valid", {15'd0, Rd_valid}, 16'd0);
    chk("rd_idle_data", Data_to_CPU, 16'h0000);
  endtask
  initial begin
    repeat (2) cyc();
    chk("rst_valid", {15'd0, Rd_valid}, 16'd0);
    chk("rst_data", Data_to_CPU, 16'h0000);
    chk("rst_wr_done", {15'd0, Wr_done}, 16'd0);
    chk("rst_err", {15'd0, Err_short}, 16'd0);
    Reset = 1'b0;
    idle();
    wr(16'h0012, 16'hBEEF, 1'b0, 1'b0, 1'b1, 2);
    rd(16'h0012, 1'b0, 1'b0, 16'hBEEF);
    wr(16'h0012, 16'h1234, 1'b1, 1'b0, 1'b1, 2);
    rd(16'h0012, 1'b0, 1'b0, 16'hBE34);
    rd(16'h0012, 1'b0, 1'b1, 16'hBE00);
    rd(16'h0012, 1'b1, 1'b0, 16'h0034);
    wr(16'h0012, 16'h0000, 1'b1, 1'b1, 1'b1, 2);
    rd(16'h0012, 1'b0, 1'b0, 16'hBE34);
    chk("err_before_short", {15'd0, Err_short}, 16'd0);
    wr(16'h0012, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1);
    chk("err_short_set", {15'd0, Err_short}, 16'd1);
    rd(16'h0012, 1'b0, 1'b0, 16'hBE34);
    wr(16'h0112, 16'hA5A5, 1'b0, 1'b0, 1'b0, 2);
    rd(16'h0012, 1'b0, 1'b0, 16'hA5A5);
    chk("err_sticky", {15'd0, Err_short}, 16'd1);
    wr(16'h0020, 16'h5A5A, 1'b0, 1'b0, 1'b1, 2);
    sb.push_back(16'hA5A5);
    sb.push_back(16'h5A5A);
    ce = 1'b0; oe = 1'b0; we = 1'b1; addr = 16'h0012;
    repeat (2) cyc();
    pop_chk("rd2_first");
    addr = 16'h0020;
    cyc();
    pop_chk("rd2_readdr");
    idle();
    Reset = 1'b1;
    cyc();
    chk("rst_clears_err", {15'd0, Err_short}, 16'd0);
    Reset = 1'b0;
    idle();
    ce = 1'b0; we = 1'b0; oe = 1'b1; addr = 16'h0012; din = 16'h0000;
    cyc();
    Reset = 1'b1;
    cyc();
    chk("rstwr_err", {15'd0, Err_short}, 16'd0);
    chk("rstwr_done", {15'd0, Wr_done}, 16'd0);
    Reset = 1'b0;
    idle();
    chk("rstwr_err_after", {15'd0, Err_short}, 16'd0);
    rd(16'h0012, 1'b0, 1'b0, 16'hA5A5);
    ce = 1'b0; oe = 1'b0; we = 1'b1; addr = 16'h0020;
    repeat (2) cyc();
    chk("rstrd_valid_pre", {15'd0, Rd_valid}, 16'd1);
    Reset = 1'b1;
    cyc();
    chk("rstrd_valid", {15'd0, Rd_valid}, 16'd0);
    chk("rstrd_data", Data_to_CPU, 16'h0000);
    Reset = 1'b0;
    idle();
`ifdef SRAM_ACCESS_CNT_EN
    chk("cnt_rd_rst", Rd_count, 16'd0);
    chk("cnt_wr_rst", Wr_count, 16'd0);
    rd(16'h0012, 1'b0, 1'b0, 16'hA5A5);
    rd(16'h0020, 1'b0, 1'b0, 16'h5A5A);
    wr(16'h0030, 16'h1111, 1'b0, 1'b0, 1'b1, 2);
    wr(16'h0031, 16'h2222, 1'b0, 1'b0, 1'b1, 2);
    rd(16'h0030, 1'b0, 1'b0, 16'h1111);
    chk("cnt_rd", Rd_count, 16'd3);
    chk("cnt_wr", Wr_count, 16'd2);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
